// File: rtl/peripheral_opsequencer.sv
// peripheral_opsequencer
//   Runs one operation of the switch-entry peripheral. It collects operand A
//   and then operand B one byte per enter press, LSB first. It strobes the ALU
//   and waits for its result, with a timeout. It then steps the result out to
//   the display one byte per press.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   reset       asynchronous active-low reset
//   clear       synchronous abort back to IDLE, clears both operands
//   enter       debounced enter level (edge-detected here)
//   inputdata   switch byte to capture
//   op_done     ALU result valid, sampled only in WAIT
//   dataR       ALU result, captured with op_done
//   op_start    one-cycle ALU start strobe, high while in START
//   dataA/dataB assembled operands (byte0 = LSB, captured first)
//   dataoutput  byte shown on the 7-seg display
//   byte_idx    index of the next byte to capture/show (0..NBYTES)
//   state_o     IDLE=0 LOAD_A=1 LOAD_B=2 START=3 WAIT=4 SHOW=5 ERR=6
//   busy        high in START or WAIT
module peripheral_opsequencer #(
  parameter int NBYTES  = 4,
  parameter int TIMEOUT = 255,
  localparam int DATA_W = 8 * NBYTES,
  // byte_idx has to reach NBYTES in SHOW, so it is one bit wider than a
  // plain byte selector when NBYTES is a power of two.
  localparam int IDX_W  = $clog2(NBYTES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enter,
  input  logic [7:0]        inputdata,
  input  logic              op_done,
  input  logic [DATA_W-1:0] dataR,
  output logic              op_start,
  output logic [DATA_W-1:0] dataA,
  output logic [DATA_W-1:0] dataB,
  output logic [7:0]        dataoutput,
  output logic [IDX_W-1:0]  byte_idx,
  output logic [2:0]        state_o,
  output logic              busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_A = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;
  localparam logic [2:0] SHOW   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  localparam int SEL_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NBYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] result_q;
  logic              enter_q;
  logic              ev;
  logic [SEL_W-1:0]  sel;
  logic              last_byte;

  // One event per press, however long the button is held.
  assign ev        = enter & ~enter_q;
  // Byte lane selector. Only used while idx < NBYTES, so truncation is safe.
  assign sel       = idx[SEL_W-1:0];
  assign last_byte = (idx == IDX_LAST);

  assign byte_idx = idx;
  assign state_o  = state;
  assign busy     = (state == START) || (state == WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      dataA      <= '0;
      dataB      <= '0;
      result_q   <= '0;
      dataoutput <= '0;
      op_start   <= 1'b0;
      // Treat the button as already pressed, so that a button held through
      // reset release does not count as a press.
      enter_q    <= 1'b1;
    end else begin
      enter_q  <= enter;
      op_start <= 1'b0;
      if (clear) begin
        state <= IDLE;
        idx   <= '0;
        cnt   <= '0;
        dataA <= '0;
        dataB <= '0;
      end else begin
        case (state)
          // IDLE and LOAD_A share the capture path. idx is 0 in IDLE, so
          // the first press lands in byte 0 of A.
          IDLE, LOAD_A: begin
            if (ev) begin
              dataA[8*sel +: 8] <= inputdata;
              dataoutput        <= inputdata;
              if (last_byte) begin
                idx   <= '0;
                state <= LOAD_B;
              end else begin
                idx   <= idx + IDX_W'(1);
                state <= LOAD_A;
              end
            end
          end
          LOAD_B: begin
            if (ev) begin
              dataB[8*sel +: 8] <= inputdata;
              dataoutput        <= inputdata;
              if (last_byte) begin
                idx      <= '0;
                state    <= START;
                // Registered together with the START state, so the strobe
                // covers exactly the START cycle.
                op_start <= 1'b1;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end
          START: begin
            cnt   <= '0;
            state <= WAIT;
          end
          WAIT: begin
            cnt <= cnt + CNT_W'(1);
            // A result arriving in the timeout cycle is still accepted.
            if (op_done) begin
              result_q   <= dataR;
              dataoutput <= dataR[7:0];
              idx        <= IDX_W'(1);
              state      <= SHOW;
            end else if (cnt == CNT_LAST) begin
              dataoutput <= 8'hEE;
              state      <= ERR;
            end
          end
          SHOW: begin
            if (ev) begin
              if (idx == IDX_END) begin
                // Leave the last byte on the display when returning to IDLE.
                idx   <= '0;
                state <= IDLE;
              end else begin
                dataoutput <= result_q[8*sel +: 8];
                idx        <= idx + IDX_W'(1);
              end
            end
          end
          ERR: begin
            dataoutput <= 8'hEE;
            if (ev) begin
              idx   <= '0;
              state <= IDLE;
            end
          end
          default: begin
            idx   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_peripheral_opsequencer.sv
module tb_peripheral_opsequencer;

  localparam int NBYTES  = 4;
  localparam int TIMEOUT = 16;
  localparam int DATA_W  = 8 * NBYTES;
  localparam int IDX_W   = $clog2(NBYTES + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic              enter;
  logic [7:0]        inputdata;
  logic              op_done;
  logic [DATA_W-1:0] dataR;
  logic              op_start;
  logic [DATA_W-1:0] dataA;
  logic [DATA_W-1:0] dataB;
  logic [7:0]        dataoutput;
  logic [IDX_W-1:0]  byte_idx;
  logic [2:0]        state_o;
  logic              busy;

  int nvec   = 0;
  int nerr   = 0;
  int starts = 0;

  peripheral_opsequencer #(.NBYTES(NBYTES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .clear(clear), .enter(enter),
    .inputdata(inputdata), .op_done(op_done), .dataR(dataR),
    .op_start(op_start), .dataA(dataA), .dataB(dataB),
    .dataoutput(dataoutput), .byte_idx(byte_idx), .state_o(state_o),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Counts the clock cycles in which the start strobe is high.
  always @(posedge clk) if (op_start === 1'b1) starts <= starts + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] d);
    inputdata = d;
    enter = 1'b1;
    step();
    enter = 1'b0;
    step();
  endtask

  // Presses all eight operand bytes. On return the sequencer is in its
  // first WAIT cycle.
  task automatic load_op(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) press(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) press(b[8*i +: 8]);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; enter = 1'b0; inputdata = 8'h00;
    op_done = 1'b0; dataR = '0;
    step(); step();
    chk("rst_state", 32'(state_o), 0);
    chk("rst_dataA", dataA, 0);
    chk("rst_dataB", dataB, 0);
    chk("rst_dout",  32'(dataoutput), 0);
    chk("rst_idx",   32'(byte_idx), 0);
    chk("rst_start", 32'(op_start), 0);
    chk("rst_busy",  32'(busy), 0);
    reset = 1'b1;
    step();

    // Load A, then three bytes of B.
    press(8'h11);
    chk("a0_state", 32'(state_o), 1);
    chk("a0_echo",  32'(dataoutput), 32'h11);
    chk("a0_idx",   32'(byte_idx), 1);
    press(8'h22); press(8'h33); press(8'h44);
    chk("a_full",   dataA, 32'h44332211);
    chk("a_to_b",   32'(state_o), 2);
    chk("a_idx0",   32'(byte_idx), 0);
    press(8'h55); press(8'h66); press(8'h77);
    chk("b_partial", dataB, 32'h00776655);
    chk("b_idx3",    32'(byte_idx), 3);
    // The last B byte: START follows with a single-cycle strobe.
    inputdata = 8'h88; enter = 1'b1;
    step();
    chk("start_state", 32'(state_o), 3);
    chk("start_pulse", 32'(op_start), 1);
    chk("start_busy",  32'(busy), 1);
    chk("b_full",      dataB, 32'h88776655);
    enter = 1'b0;
    step();
    chk("wait_state",  32'(state_o), 4);
    chk("start_low",   32'(op_start), 0);
    chk("wait_busy",   32'(busy), 1);
    chk("start_count", starts, 1);
    // A press during WAIT has no effect.
    press(8'h99);
    chk("wait_ign_st",  32'(state_o), 4);
    chk("wait_ign_idx", 32'(byte_idx), 0);
    chk("wait_ign_out", 32'(dataoutput), 32'h88);
    step(); step();
    op_done = 1'b1; dataR = 32'hDEADBEEF;
    step();
    op_done = 1'b0; dataR = 32'h12345678;
    chk("show_state", 32'(state_o), 5);
    chk("show_b0",    32'(dataoutput), 32'hEF);
    chk("show_idx1",  32'(byte_idx), 1);
    chk("show_busy",  32'(busy), 0);
    // An op_done pulse outside WAIT is ignored.
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    chk("show_ign_done", 32'(dataoutput), 32'hEF);
    press(8'h00); chk("show_b1", 32'(dataoutput), 32'hBE);
    press(8'h00); chk("show_b2", 32'(dataoutput), 32'hAD);
    press(8'h00); chk("show_b3", 32'(dataoutput), 32'hDE);
    chk("show_idx4", 32'(byte_idx), 4);
    press(8'h00);
    chk("show_idle",  32'(state_o), 0);
    chk("show_idx0",  32'(byte_idx), 0);
    chk("show_keep",  32'(dataoutput), 32'hDE);
    chk("a_retained", dataA, 32'h44332211);

    // Timeout: still in WAIT after 15 cycles, ERR after the 16th.
    load_op(32'h04030201, 32'h08070605);
    repeat (15) step();
    chk("to_wait15", 32'(state_o), 4);
    step();
    chk("to_err",    32'(state_o), 6);
    chk("to_ee",     32'(dataoutput), 32'hEE);
    press(8'h00);
    chk("err_idle",  32'(state_o), 0);
    chk("err_idx",   32'(byte_idx), 0);

    // op_done in the timeout cycle takes priority over the timeout.
    load_op(32'h0, 32'h0);
    repeat (15) step();
    op_done = 1'b1; dataR = 32'hCAFEF00D;
    step();
    op_done = 1'b0;
    chk("race_show", 32'(state_o), 5);
    chk("race_b0",   32'(dataoutput), 32'h0D);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_show_idle", 32'(state_o), 0);
    chk("clr_show_idx",  32'(byte_idx), 0);

    // Holding enter for 50 cycles captures only one byte.
    press(8'hA1);
    inputdata = 8'hB2; enter = 1'b1;
    repeat (50) step();
    enter = 1'b0;
    step();
    chk("hold_idx", 32'(byte_idx), 2);
    chk("hold_a",   dataA, 32'h0000B2A1);
    press(8'hC3); press(8'hD4);
    chk("hold_afull", dataA, 32'hD4C3B2A1);

    // clear together with a press after three B bytes.
    press(8'h01); press(8'h02); press(8'h03);
    chk("clr_pre_b", dataB, 32'h00030201);
    inputdata = 8'h04; clear = 1'b1; enter = 1'b1;
    step();
    clear = 1'b0; enter = 1'b0;
    step();
    chk("clr_state", 32'(state_o), 0);
    chk("clr_a",     dataA, 0);
    chk("clr_b",     dataB, 0);
    chk("clr_idx",   32'(byte_idx), 0);
    chk("clr_nostart", starts, 3);
    op_done = 1'b1; dataR = 32'h55AA55AA;
    step();
    op_done = 1'b0;
    chk("late_done_st",  32'(state_o), 0);
    chk("late_done_out", 32'(dataoutput), 32'h03);

    // Asynchronous reset during WAIT, with enter held through the release.
    load_op(32'h13121110, 32'h17161514);
    chk("pre_rst_wait", 32'(state_o), 4);
    enter = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("arst_state", 32'(state_o), 0);
    chk("arst_a",     dataA, 0);
    chk("arst_b",     dataB, 0);
    chk("arst_out",   32'(dataoutput), 0);
    chk("arst_busy",  32'(busy), 0);
    chk("arst_start", 32'(op_start), 0);
    step();
    reset = 1'b1;
    repeat (3) step();
    chk("held_noev", 32'(state_o), 0);
    enter = 1'b0;
    step();
    press(8'h5A);
    chk("post_rst_st",  32'(state_o), 1);
    chk("post_rst_out", 32'(dataoutput), 32'h5A);
    chk("post_rst_a",   dataA, 32'h0000005A);
    chk("start_total",  starts, 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
